// File: rtl/axi4_pkg.sv
// Shared AXI4 types and burst helpers used by the RAM responder and its address generators.
package axi4_pkg;

    localparam int AXI_ID_WIDTH = 4;

    typedef logic [AXI_ID_WIDTH-1:0] axi_id_t;
    typedef logic [7:0]              axi_len_t;
    typedef logic [2:0]              axi_size_t;
    typedef logic [63:0]             axi_addr_ext_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED    = 2'b00,
        AXI_BURST_INCR     = 2'b01,
        AXI_BURST_WRAP     = 2'b10,
        AXI_BURST_RESERVED = 2'b11
    } axi_burst_t;

    typedef enum logic {
        AXI_LOCK_NORMAL    = 1'b0,
        AXI_LOCK_EXCLUSIVE = 1'b1
    } axi_lock_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic axi_wrap_len_ok(axi_len_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic int unsigned axi_size_bytes(axi_size_t size);
        return 32'd1 << size;
    endfunction

    function automatic axi_addr_ext_t axi_next_addr(axi_addr_ext_t addr, axi_size_t size,
                                                    axi_len_t len, axi_burst_t burst);
        axi_addr_ext_t bytes;
        axi_addr_ext_t aligned;
        axi_addr_ext_t span;
        axi_addr_ext_t base;
        axi_addr_ext_t nxt;
        bytes   = 64'(axi_size_bytes(size));
        aligned = addr & ~(bytes - 64'd1);
        span    = bytes * (64'(len) + 64'd1);
        base    = addr & ~(span - 64'd1);
        nxt     = addr;
        case (burst)
            AXI_BURST_INCR: nxt = aligned + bytes;
            AXI_BURST_WRAP: nxt = (aligned + bytes == base + span) ? base : aligned + bytes;
            default:        nxt = addr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Per-burst address generator: latches the AW/AR attributes and steps one beat per advance.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  axi_len_t              len_i,
    input  axi_size_t             size_i,
    input  axi_burst_t            burst_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  illegal_o
);

    localparam int unsigned BUS_BYTES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] addr_q;
    axi_len_t              len_q;
    axi_size_t             size_q;
    axi_burst_t            burst_q;
    axi_len_t              count_q;
    logic                  illegal_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= AXI_BURST_FIXED;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else if (load_i) begin
            addr_q    <= addr_i;
            len_q     <= len_i;
            size_q    <= size_i;
            burst_q   <= burst_i;
            count_q   <= '0;
            illegal_q <= (burst_i == AXI_BURST_RESERVED)
                       || ((burst_i == AXI_BURST_WRAP) && !axi_wrap_len_ok(len_i))
                       || (axi_size_bytes(size_i) > BUS_BYTES);
        end else if (advance_i) begin
            addr_q  <= ADDR_WIDTH'(axi_next_addr(64'(addr_q), size_q, len_q, burst_q));
            count_q <= count_q + 8'd1;
        end
    end

    assign addr_o    = addr_q;
    assign last_o    = (count_q == len_q);
    assign illegal_o = illegal_q;

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 responder in front of a word-addressed RAM with independent write and read FSMs.
module axi4_ram_slave
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  axi_id_t                 awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  axi_len_t                awlen_i,
    input  axi_size_t               awsize_i,
    input  axi_burst_t              awburst_i,
    input  axi_lock_t               awlock_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output axi_id_t                 bid_o,
    output axi_resp_t               bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  axi_id_t                 arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  axi_len_t                arlen_i,
    input  axi_size_t               arsize_i,
    input  axi_burst_t              arburst_i,
    input  axi_lock_t               arlock_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output axi_id_t                 rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output axi_resp_t               rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output wr_state_t               wr_state_o,
    output rd_state_t               rd_state_o
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // valid never waits on ready, and payloads hold steady while valid is high without ready.
    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * (DATA_WIDTH / 8));

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Exclusive accesses are served as normal ones, so the lock attribute is ignored.
    logic unused_lock;
    assign unused_lock = ^{awlock_i, arlock_i};

    wr_state_t             w_state, w_next;
    logic                  awready_q, err_q;
    axi_id_t               bid_q;
    axi_resp_t             bresp_q;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_last, w_illegal, w_in_range;
    logic                  aw_hs, w_hs, w_en, w_beat_err, w_done;

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_addr (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(aw_hs), .addr_i(awaddr_i), .len_i(awlen_i),
        .size_i(awsize_i), .burst_i(awburst_i), .advance_i(w_hs),
        .addr_o(w_addr), .last_o(w_last), .illegal_o(w_illegal)
    );

    assign aw_hs      = awvalid_i && awready_q;
    assign w_hs       = wvalid_i && (w_state == W_DATA);
    assign w_in_range = {1'b0, w_addr} < MEM_BYTES;
    assign w_en       = w_hs && w_in_range && !w_illegal;
    assign w_beat_err = w_illegal || !w_in_range || (wlast_i != w_last);
    assign w_done     = w_hs && (wlast_i || w_last);

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_done) w_next = W_RESP;
            W_RESP:  if (bready_i) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            err_q     <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            if (aw_hs) begin
                bid_q <= awid_i;
                err_q <= 1'b0;
            end else if (w_hs) begin
                err_q <= err_q || w_beat_err;
            end
            if (w_done) bresp_q <= (err_q || w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb_i[b]) mem[w_addr[ADDR_LSB +: IDX_W]][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign awready_o  = awready_q;
    assign wready_o   = (w_state == W_DATA);
    assign bvalid_o   = (w_state == W_RESP);
    assign bid_o      = bid_q;
    assign bresp_o    = bresp_q;
    assign wr_state_o = w_state;

    rd_state_t             r_state, r_next;
    logic                  arready_q, rlast_q;
    axi_id_t               ar_id_q, rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    axi_resp_t             rresp_q;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_last, r_illegal, r_ok;
    logic                  ar_hs, r_hs;

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_addr (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(ar_hs), .addr_i(araddr_i), .len_i(arlen_i),
        .size_i(arsize_i), .burst_i(arburst_i), .advance_i(r_hs && !rlast_q),
        .addr_o(r_addr), .last_o(r_last), .illegal_o(r_illegal)
    );

    assign ar_hs = arvalid_i && arready_q;
    assign r_hs  = rready_i && (r_state == R_DATA);
    assign r_ok  = !r_illegal && ({1'b0, r_addr} < MEM_BYTES);

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (rready_i) r_next = rlast_q ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    // The RAM read is registered here, so a same-cycle write to the word is seen next beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            ar_id_q   <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (ar_hs) ar_id_q <= arid_i;
            if (r_state == R_FETCH) begin
                rdata_q <= r_ok ? mem[r_addr[ADDR_LSB +: IDX_W]] : '0;
                rresp_q <= r_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                rid_q   <= ar_id_q;
                rlast_q <= r_last;
            end
        end
    end

    assign arready_o  = arready_q;
    assign rvalid_o   = (r_state == R_DATA);
    assign rid_o      = rid_q;
    assign rdata_o    = rdata_q;
    assign rresp_o    = rresp_q;
    assign rlast_o    = rlast_q;
    assign rd_state_o = r_state;

endmodule
